// File: rtl/rf_pkg.sv
// Shared defaults for the bypassing register file and its scoreboard.
// rf_clog2 derives a select width from a register count at instantiation.
package rf_pkg;
  localparam int RF_DATA_WIDTH = 16;
  localparam int RF_NUM_REGS   = 8;
  localparam int RF_ADDR_WIDTH = 3;

  function automatic int rf_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: reserve sets, writeback clears, reserve wins a tie.
// busy_vec updates one edge after the request; err_det is a same-cycle flag; never stalls.
module rf_scoreboard #(
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_sel,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_sel,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  err_det
);
  logic [NUM_REGS-1:0] rsv_hit;
  logic [NUM_REGS-1:0] rsv_set;
  logic [NUM_REGS-1:0] wr_clr;
  logic [NUM_REGS-1:0] busy_nxt;

  always_comb begin
    rsv_hit  = '0;
    rsv_set  = '0;
    wr_clr   = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      rsv_hit[r] = rsv_en && (rsv_sel == ADDR_WIDTH'(r));
      rsv_set[r] = rsv_hit[r] && !(ZERO_REG != 0 && r == 0);
      wr_clr[r]  = wr_en && (wr_sel == ADDR_WIDTH'(r));
    end
    busy_nxt = rsv_set | (busy_vec & ~wr_clr);
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    // A same-cycle writeback retires the old producer, so re-reserving it is not a WAW.
    err_det  = (rsv_en && !(|rsv_hit)) || (|(rsv_set & busy_vec & ~wr_clr));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_vec <= '0;
    else     busy_vec <= busy_nxt;
  end
endmodule

// File: rtl/rf_bypass_sb.sv
// Multi-port register file with same-cycle write bypass, optional zero register and busy scoreboard.
// Reads are combinational; writes, busy and err update on the next edge; never stalls.
module rf_bypass_sb
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_sel,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]            rd_busy,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_sel,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           rsv_en,
  input  logic [ADDR_WIDTH-1:0]          rsv_sel,
  output logic [NUM_REGS-1:0]            busy_vec,
  output logic                           err
);
  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_hit;
  logic [NUM_REGS-1:0]   wr_store;
  logic                  wr_oor;
  logic                  sb_err;

  always_comb begin
    wr_hit   = '0;
    wr_store = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_hit[r]   = wr_en && (wr_sel == ADDR_WIDTH'(r));
      wr_store[r] = wr_hit[r] && !(ZERO_REG != 0 && r == 0);
    end
    wr_oor = wr_en && !(|wr_hit);
  end

  // With the zero register enabled, mem[0] is never stored to and stays at its reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_store[r]) mem[r] <= wr_data;
      end
    end
  end

  rf_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .rsv_en  (rsv_en),
    .rsv_sel (rsv_sel),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .busy_vec(busy_vec),
    .err_det (sb_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  err <= 1'b0;
    else if (wr_oor || sb_err) err <= 1'b1;
  end

  // Out-of-range selects match no register and fall through to zero / not busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    if (!rst) begin
      for (int i = 0; i < NUM_READ; i++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          if (rd_sel[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
            rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_store[r] ? wr_data : mem[r];
            rd_busy[i] = busy_vec[r] && !wr_hit[r];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_rf_bypass_sb.sv
// Bench for rf_bypass_sb: default 8x16 2-read instance plus a 6-register zero-reg 4-read instance.
module tb_rf_bypass_sb;
  import rf_pkg::*;

  localparam int Z_REGS = 6;
  localparam int Z_AW   = rf_clog2(Z_REGS);

  logic clk = 1'b0;
  logic rst;

  logic [5:0]  rd_sel0;
  logic [31:0] rd_data0;
  logic [1:0]  rd_busy0;
  logic        wr_en0;
  logic [2:0]  wr_sel0;
  logic [15:0] wr_data0;
  logic        rsv_en0;
  logic [2:0]  rsv_sel0;
  logic [7:0]  busy_vec0;
  logic        err0;

  logic [4*Z_AW-1:0] rd_sel1;
  logic [63:0]       rd_data1;
  logic [3:0]        rd_busy1;
  logic              wr_en1;
  logic [Z_AW-1:0]   wr_sel1;
  logic [15:0]       wr_data1;
  logic              rsv_en1;
  logic [Z_AW-1:0]   rsv_sel1;
  logic [Z_REGS-1:0] busy_vec1;
  logic              err1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_bypass_sb u_dut (
    .clk(clk), .rst(rst), .rd_sel(rd_sel0), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wr_en(wr_en0), .wr_sel(wr_sel0), .wr_data(wr_data0), .rsv_en(rsv_en0),
    .rsv_sel(rsv_sel0), .busy_vec(busy_vec0), .err(err0)
  );

  rf_bypass_sb #(
    .DATA_WIDTH(16), .NUM_REGS(Z_REGS), .ADDR_WIDTH(Z_AW), .NUM_READ(4), .ZERO_REG(1)
  ) u_dz (
    .clk(clk), .rst(rst), .rd_sel(rd_sel1), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wr_en(wr_en1), .wr_sel(wr_sel1), .wr_data(wr_data1), .rsv_en(rsv_en1),
    .rsv_sel(rsv_sel1), .busy_vec(busy_vec1), .err(err1)
  );

  // Reference model: index 0 = default instance, 1 = zero-register instance.
  logic [15:0] mdl_mem  [2][8];
  bit          mdl_busy [2][8];
  bit          mdl_err  [2];

  function automatic int nregs(int k);
    return (k == 0) ? 8 : Z_REGS;
  endfunction

  function automatic bit is_zero(int k, int r);
    return (k == 1) && (r == 0);
  endfunction

  function automatic logic [15:0] exp_rd(int k, int s, bit we, int ws, logic [15:0] wd);
    if (s >= nregs(k) || is_zero(k, s)) return 16'h0;
    if (we && ws == s) return wd;
    return mdl_mem[k][s];
  endfunction

  function automatic bit exp_rb(int k, int s, bit we, int ws);
    if (s >= nregs(k)) return 1'b0;
    return mdl_busy[k][s] && !(we && ws == s);
  endfunction

  function automatic logic [7:0] exp_bv(int k);
    logic [7:0] v = '0;
    for (int r = 0; r < nregs(k); r++) v[r] = mdl_busy[k][r];
    return v;
  endfunction

  task automatic mdl_reset();
    for (int k = 0; k < 2; k++) begin
      mdl_err[k] = 1'b0;
      for (int r = 0; r < 8; r++) begin
        mdl_mem[k][r]  = 16'h0;
        mdl_busy[k][r] = 1'b0;
      end
    end
  endtask

  task automatic mdl_step(int k, bit we, int ws, logic [15:0] wd, bit re, int rs);
    int n;
    bit rs_ok;
    n     = nregs(k);
    rs_ok = re && rs < n && !is_zero(k, rs);
    if (we && ws >= n) mdl_err[k] = 1'b1;
    if (re && rs >= n) mdl_err[k] = 1'b1;
    if (rs_ok && mdl_busy[k][rs] && !(we && ws == rs)) mdl_err[k] = 1'b1;
    if (we && ws < n) begin
      if (!is_zero(k, ws)) mdl_mem[k][ws] = wd;
      mdl_busy[k][ws] = 1'b0;
    end
    if (rs_ok) mdl_busy[k][rs] = 1'b1;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (!rst) begin
      mdl_step(0, wr_en0, int'(wr_sel0), wr_data0, rsv_en0, int'(rsv_sel0));
      mdl_step(1, wr_en1, int'(wr_sel1), wr_data1, rsv_en1, int'(rsv_sel1));
    end
    #1;
  endtask

  task automatic chk_comb0(string tag);
    int s;
    for (int i = 0; i < 2; i++) begin
      s = int'(rd_sel0[i*3 +: 3]);
      chk($sformatf("%s_d0p%0d", tag, i), 64'(rd_data0[i*16 +: 16]),
          64'(exp_rd(0, s, wr_en0, int'(wr_sel0), wr_data0)));
      chk($sformatf("%s_b0p%0d", tag, i), 64'(rd_busy0[i]),
          64'(exp_rb(0, s, wr_en0, int'(wr_sel0))));
    end
  endtask

  task automatic chk_comb1(string tag);
    int s;
    for (int i = 0; i < 4; i++) begin
      s = int'(rd_sel1[i*Z_AW +: Z_AW]);
      chk($sformatf("%s_d1p%0d", tag, i), 64'(rd_data1[i*16 +: 16]),
          64'(exp_rd(1, s, wr_en1, int'(wr_sel1), wr_data1)));
      chk($sformatf("%s_b1p%0d", tag, i), 64'(rd_busy1[i]),
          64'(exp_rb(1, s, wr_en1, int'(wr_sel1))));
    end
  endtask

  task automatic chk_state(string tag);
    chk({tag, "_bv0"},  64'(busy_vec0), 64'(exp_bv(0)));
    chk({tag, "_err0"}, 64'(err0),      64'(mdl_err[0]));
    chk({tag, "_bv1"},  64'(busy_vec1), 64'(exp_bv(1)));
    chk({tag, "_err1"}, 64'(err1),      64'(mdl_err[1]));
  endtask

  task automatic idle_inputs();
    wr_en0 = 1'b0; wr_sel0 = 3'd0; wr_data0 = 16'h0; rsv_en0 = 1'b0; rsv_sel0 = 3'd0;
    rd_sel0 = 6'd0;
    wr_en1 = 1'b0; wr_sel1 = '0; wr_data1 = 16'h0; rsv_en1 = 1'b0; rsv_sel1 = '0;
    rd_sel1 = '0;
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  ws;
    logic [15:0] wd;
    bit          re;
    logic [2:0]  rs;
    logic [2:0]  s0;
    logic [2:0]  s1;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [1:0]  eb;
    logic [7:0]  ebv;
    bit          eerr;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // we ws wd re rs | s0 s1 | e0 e1 | rd_busy | busy_vec after | err after
    tbl[0]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd3, 16'h0000, 16'h0000, 2'b00, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 3'd5, 3'd3, 16'hBEEF, 16'h0000, 2'b00, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF, 2'b00, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 3'd2, 16'h1234, 1'b0, 3'd0, 3'd2, 3'd2, 16'h1234, 16'h1234, 2'b00, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd5, 16'h1234, 16'hBEEF, 2'b00, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd4, 3'd4, 16'h0000, 16'h0000, 2'b00, 8'h10, 1'b0};
    tbl[6]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd4, 16'h1234, 16'h0000, 2'b10, 8'h10, 1'b0};
    tbl[7]  = '{1'b1, 3'd4, 16'h0007, 1'b0, 3'd0, 3'd4, 3'd4, 16'h0007, 16'h0007, 2'b00, 8'h00, 1'b0};
    tbl[8]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd6, 3'd6, 16'h0000, 16'h0000, 2'b00, 8'h40, 1'b0};
    tbl[9]  = '{1'b1, 3'd6, 16'h00AB, 1'b1, 3'd6, 3'd6, 3'd4, 16'h00AB, 16'h0007, 2'b00, 8'h40, 1'b0};
    tbl[10] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd6, 3'd4, 16'h00AB, 16'h0007, 2'b01, 8'h40, 1'b0};
    tbl[11] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd6, 3'd6, 16'h00AB, 16'h00AB, 2'b11, 8'h40, 1'b1};
    tbl[12] = '{1'b1, 3'd1, 16'h5555, 1'b0, 3'd0, 3'd1, 3'd6, 16'h5555, 16'h00AB, 2'b10, 8'h40, 1'b1};

    rst = 1'b1;
    idle_inputs();
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bv0",  64'(busy_vec0), 64'h0);
    chk("rst_err0", 64'(err0),      64'h0);
    chk("rst_rd0",  64'(rd_data0),  64'h0);
    rst = 1'b0;

    // Directed table on the default instance
    for (int v = 0; v < 13; v++) begin
      wr_en0 = tbl[v].we; wr_sel0 = tbl[v].ws; wr_data0 = tbl[v].wd;
      rsv_en0 = tbl[v].re; rsv_sel0 = tbl[v].rs;
      rd_sel0 = {tbl[v].s1, tbl[v].s0};
      #1;
      chk($sformatf("tbl%0d_rd0", v), 64'(rd_data0[15:0]),  64'(tbl[v].e0));
      chk($sformatf("tbl%0d_rd1", v), 64'(rd_data0[31:16]), 64'(tbl[v].e1));
      chk($sformatf("tbl%0d_rb",  v), 64'(rd_busy0),        64'(tbl[v].eb));
      edge_step();
      chk($sformatf("tbl%0d_bv",  v), 64'(busy_vec0), 64'(tbl[v].ebv));
      chk($sformatf("tbl%0d_err", v), 64'(err0),      64'(tbl[v].eerr));
    end
    idle_inputs();

    // Zero register: write and reserve to R0 are dropped, no bypass on R0
    wr_en1 = 1'b1; wr_sel1 = '0; wr_data1 = 16'hFFFF; rsv_en1 = 1'b1; rsv_sel1 = '0;
    rd_sel1 = '0;
    #1;
    chk("z_byp", rd_data1, 64'h0);
    edge_step();
    chk("z_bv0",  64'(busy_vec1[0]), 64'h0);
    chk("z_err0", 64'(err1),         64'h0);
    wr_en1 = 1'b0; rsv_en1 = 1'b0;
    #1;
    chk("z_rd0", rd_data1, 64'h0);
    for (int r = 1; r < Z_REGS; r++) begin
      wr_en1 = 1'b1; wr_sel1 = Z_AW'(r); wr_data1 = 16'(r * 'h1111);
      edge_step();
    end
    wr_en1 = 1'b0;
    rd_sel1 = {3'd1, 3'd2, 3'd4, 3'd5};
    #1;
    chk("z_quad", rd_data1, 64'h1111_2222_4444_5555);
    chk_comb1("z_quad");
    rd_sel1 = {3'd6, 3'd7, 3'd6, 3'd0};
    #1;
    chk("z_oor_rd", rd_data1, 64'h0);
    edge_step();
    chk("z_oor_noerr", 64'(err1), 64'h0);
    wr_en1 = 1'b1; wr_sel1 = 3'd7; wr_data1 = 16'h9999;
    edge_step();
    wr_en1 = 1'b0;
    chk("z_oor_wr_err", 64'(err1), 64'h1);
    rd_sel1 = {3'd1, 3'd2, 3'd4, 3'd5};
    #1;
    chk("z_unchanged", rd_data1, 64'h1111_2222_4444_5555);
    chk_state("z_end");
    idle_inputs();

    // Asynchronous reset in the middle of a cycle
    rsv_en0 = 1'b1; rsv_sel0 = 3'd1; wr_en0 = 1'b1; wr_sel0 = 3'd3; wr_data0 = 16'hAAAA;
    edge_step();
    wr_en0 = 1'b0;
    edge_step();
    chk("ar_pre_bv",  64'(busy_vec0), 64'h42);
    chk("ar_pre_err", 64'(err0),      64'h1);
    rsv_en0 = 1'b0;
    rd_sel0 = {3'd3, 3'd1};
    #1;
    chk("ar_pre_r3", 64'(rd_data0[31:16]), 64'hAAAA);
    #1;
    rst = 1'b1;
    wr_en0 = 1'b1; wr_sel0 = 3'd3; wr_data0 = 16'h1234; rd_sel0 = {3'd3, 3'd3};
    #1;
    mdl_reset();
    chk("ar_rd",   64'(rd_data0),  64'h0);
    chk("ar_rb",   64'(rd_busy0),  64'h0);
    chk("ar_bv",   64'(busy_vec0), 64'h0);
    chk("ar_err0", 64'(err0),      64'h0);
    chk("ar_err1", 64'(err1),      64'h0);
    wr_en0 = 1'b0; rsv_en0 = 1'b1; rsv_sel0 = 3'd1; rd_sel0 = {3'd3, 3'd1};
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_post_rd", 64'(rd_data0), 64'h0);
    edge_step();
    chk("ar_post_bv",  64'(busy_vec0), 64'h02);
    chk("ar_post_err", 64'(err0),      64'h0);
    chk_state("ar_post");

    // Randomised traffic on both instances against the model
    for (int c = 0; c < 300; c++) begin
      wr_en0   = 1'($urandom_range(0, 1));
      wr_sel0  = 3'($urandom_range(0, 7));
      wr_data0 = 16'($urandom);
      rsv_en0  = ($urandom_range(0, 2) == 0);
      rsv_sel0 = 3'($urandom_range(0, 7));
      rd_sel0  = 6'($urandom);
      if ($urandom_range(0, 3) == 0) rd_sel0[2:0] = wr_sel0;
      wr_en1   = 1'($urandom_range(0, 1));
      wr_sel1  = Z_AW'($urandom_range(0, 7));
      wr_data1 = 16'($urandom);
      rsv_en1  = ($urandom_range(0, 2) == 0);
      rsv_sel1 = Z_AW'($urandom_range(0, 7));
      rd_sel1  = (4*Z_AW)'($urandom);
      if ($urandom_range(0, 3) == 0) rd_sel1[Z_AW-1:0] = wr_sel1;
      #1;
      chk_comb0($sformatf("rnd%0d", c));
      chk_comb1($sformatf("rnd%0d", c));
      edge_step();
      chk_state($sformatf("rnd%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_bypass_sb.md
Name: rf_bypass_sb

Overview:
Parametrised multi-port register file that generalises the current 8x16, 2-read/1-write file. Adds same-cycle write-to-read bypass, an optional hard-wired zero register, and a per-register busy scoreboard. Decode reserves a destination at issue; writeback clears the reservation. Sits between decode (read/reserve) and writeback (write); the busy outputs feed hazard/stall logic.

Parameters:
DATA_WIDTH, 16, bits per register
NUM_REGS, 8, number of architectural registers (>=2, need not be a power of 2)
ADDR_WIDTH, 3, select width; must satisfy 2**ADDR_WIDTH >= NUM_REGS
NUM_READ, 2, number of independent read ports (1..4)
ZERO_REG, 0, 1 = register 0 reads as zero, ignores writes, is never busy

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
rd_sel  in  NUM_READ*ADDR_WIDTH  read selects; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  out  NUM_READ*DATA_WIDTH  read data, same packing
rd_busy  out  NUM_READ  port i operand not yet available
wr_en  in  1  write enable
wr_sel  in  ADDR_WIDTH  write register select
wr_data  in  DATA_WIDTH  write data
rsv_en  in  1  reserve a destination (set busy)
rsv_sel  in  ADDR_WIDTH  register to reserve
busy_vec  out  NUM_REGS  registered scoreboard, bit r = register r busy
err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, immediate on rst high): all registers = 0, busy_vec = 0, err = 0. rd_data = 0 and rd_busy = 0 while rst is high.
- Storage: array of NUM_REGS x DATA_WIDTH flops. Write takes effect at the rising edge when wr_en=1 and wr_sel < NUM_REGS.
- Read: combinational, zero latency.
  - rd_data[i] = wr_data if wr_en && wr_sel==rd_sel[i] (bypass); otherwise mem[rd_sel[i]].
  - Out-of-range rd_sel (>= NUM_REGS) returns 0.
- ZERO_REG=1:
  - reads of register 0 return 0, including when a write to register 0 is in flight (no bypass).
  - wr_en to register 0 is dropped.
  - rsv_en to register 0 is ignored; busy_vec[0] is constant 0.
- Scoreboard, next-state per register r:
  - set if rsv_en && rsv_sel==r
  - else clear if wr_en && wr_sel==r
  - else hold
  - Simultaneous reserve and write to the same r: reservation wins and busy stays 1. The write data is still stored, since the new producer overwrites it later.
- rd_busy[i] = busy_vec[rd_sel[i]] && !(wr_en && wr_sel==rd_sel[i]). A same-cycle writeback satisfies the operand through the bypass. Out-of-range select gives rd_busy=0.
- err is registered and sticky until rst. Set at the edge after any of:
  - (a) wr_en with wr_sel >= NUM_REGS
  - (b) rsv_en with rsv_sel >= NUM_REGS
  - (c) rsv_en to a register that is already busy and not cleared by a same-cycle write (double reservation / WAW)
  - Out-of-range reads do not set err.
- Writes to a non-busy register are legal: legacy path with no reservation and no err.
- Reset asserted mid-operation: all state is cleared immediately. Pending reservations are discarded. The first edge after deassertion behaves as from a clean state.
- No internal latency beyond one edge for write, busy and err updates. No stalls or backpressure are generated internally.

Decomposition:
- Shared package rf_pkg holds:
  - default constants RF_DATA_WIDTH=16, RF_NUM_REGS=8, RF_ADDR_WIDTH=3
  - function rf_clog2 for deriving ADDR_WIDTH at instantiation
- One natural sub-module, rf_scoreboard. It owns busy_vec, the set/clear priority and err conditions (b)/(c), with inputs rsv_en/rsv_sel/wr_en/wr_sel.
- The data array, bypass muxes and err condition (a) stay in rf_bypass_sb. rd_busy gating lives in rf_bypass_sb.

Test Plan:
1. Reset then read: rst pulse; rd_sel={3,0} -> rd_data=0 on both ports, busy_vec=0, err=0. Write R5=16'hBEEF; next cycle rd_sel[0]=5 -> 16'hBEEF.
2. Bypass: in one cycle, wr_en=1, wr_sel=2, wr_data=16'h1234, rd_sel={2,2} -> both rd_data=16'h1234 combinationally before the edge. After the edge, the stored value reads 16'h1234.
3. Scoreboard: rsv_en R4 -> busy_vec=8'h10 after the edge; rd_sel[1]=4 gives rd_busy[1]=1. Write R4=16'h0007 -> same cycle rd_busy[1]=0 and rd_data=7; after the edge, busy_vec=0.
4. Reserve/write collision: busy R6 set; one cycle with rsv_en R6 and wr_en R6 -> busy_vec[6] stays 1, err stays 0. Next cycle rsv_en R6 again with no write -> err=1 after the edge and stays 1 until rst.
5. ZERO_REG=1, NUM_REGS=6, ADDR_WIDTH=3: write R0=16'hFFFF, rsv R0 -> reads 0, busy_vec[0]=0. wr_sel=7 -> err=1, array unchanged. rd_sel=6 -> rd_data=0, err unaffected.
6. Async reset mid-operation: R1 busy and R3=16'hAAAA, then assert rst between edges -> immediately busy_vec=0, reads 0, err=0. NUM_READ=4 variant: four distinct selects all return correct data in the same cycle.
